// File: rtl/if_ctrl.sv
// rtl/if_ctrl.sv - instruction-fetch stage control FSM
//
// Purpose: sequences instruction-memory requests, PC/IF-ID register hold and
// bubble control, branch/exception redirect selection and request timeout.
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst       in   synchronous active-high reset
//   imem_req  out  fetch request to instruction memory
//   imem_ack  in   memory completes the current request this cycle
//   stall_id  in   decode hazard stall (hold IF/ID)
//   br_taken  in   pulse: branch resolved taken
//   exc_req   in   pulse: exception raised downstream
//   hold_pc   out  PC register keeps its value
//   hold_if   out  IF/ID register keeps its value
//   flush_if  out  IF/ID register loads a bubble
//   br_sel    out  next-PC mux selects branch target
//   exc_sel   out  next-PC mux selects exception vector
//   imem_err  out  one-cycle pulse on request timeout
module if_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  output logic imem_req,
  input  logic imem_ack,
  input  logic stall_id,
  input  logic br_taken,
  input  logic exc_req,
  output logic hold_pc,
  output logic hold_if,
  output logic flush_if,
  output logic br_sel,
  output logic exc_sel,
  output logic imem_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       pend_br, pend_br_nxt;
  logic       pend_exc, pend_exc_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;

  logic exc_cls, br_cls, redirect, timeout;

  // Exception class always wins over branch class when both are present.
  assign exc_cls  = exc_req | pend_exc;
  assign br_cls   = br_taken | pend_br;
  assign redirect = exc_cls | br_cls;
  assign timeout  = (state == FETCH) && !imem_ack && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend_br  <= 1'b0;
      pend_exc <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      pend_br  <= pend_br_nxt;
      pend_exc <= pend_exc_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pend_br_nxt  = pend_br;
    pend_exc_nxt = pend_exc;
    wait_cnt_nxt = 8'd0;
    // Redirect requests that cannot be serviced this cycle are remembered;
    // a new exception discards any remembered branch.
    if (exc_req) begin
      pend_exc_nxt = 1'b1;
      pend_br_nxt  = 1'b0;
    end else if (br_taken && !pend_exc) begin
      pend_br_nxt = 1'b1;
    end
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (imem_ack) begin
          pend_br_nxt  = 1'b0;
          pend_exc_nxt = 1'b0;
          // Leaving pending bits untouched is equivalent when no redirect
          // is active, since then both are already zero.
          if (!redirect) begin
            pend_br_nxt  = pend_br;
            pend_exc_nxt = pend_exc;
          end
        end else if (timeout) begin
          pend_exc_nxt = 1'b1;
          pend_br_nxt  = 1'b0;
          state_nxt    = ABORT;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ABORT: begin
        // The exception redirect issued here satisfies every pending request.
        state_nxt    = FETCH;
        pend_br_nxt  = 1'b0;
        pend_exc_nxt = 1'b0;
      end
      default: begin
        state_nxt    = IDLE;
        pend_br_nxt  = 1'b0;
        pend_exc_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    hold_pc  = 1'b1;
    hold_if  = 1'b0;
    flush_if = 1'b1;
    br_sel   = 1'b0;
    exc_sel  = 1'b0;
    imem_err = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack && redirect) begin
            hold_pc  = 1'b0;
            exc_sel  = exc_cls;
            br_sel   = !exc_cls;
          end else if (imem_ack && !stall_id) begin
            hold_pc  = 1'b0;
            flush_if = 1'b0;
          end else if (imem_ack || stall_id) begin
            // Stalled decode: keep IF/ID, refetch the same PC.
            hold_if  = 1'b1;
            flush_if = 1'b0;
          end
          imem_err = timeout;
        end
        ABORT: begin
          hold_pc = 1'b0;
          exc_sel = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_ctrl.sv
// tb/tb_if_ctrl.sv - self-checking bench for if_ctrl
module tb_if_ctrl;

  localparam int TO = 15;

  // Output vector order: {imem_req, hold_pc, hold_if, flush_if, br_sel, exc_sel, imem_err}
  localparam logic [6:0] O_IDLE  = 7'b0101000;
  localparam logic [6:0] O_WAIT  = 7'b1101000;
  localparam logic [6:0] O_WSTL  = 7'b1110000;
  localparam logic [6:0] O_ADV   = 7'b1000000;
  localparam logic [6:0] O_HOLD  = 7'b1110000;
  localparam logic [6:0] O_BR    = 7'b1001100;
  localparam logic [6:0] O_EXC   = 7'b1001010;
  localparam logic [6:0] O_ABORT = 7'b0001010;
  localparam logic [6:0] O_TOUT  = 7'b1101001;

  logic clk = 1'b0;
  logic rst, imem_ack, stall_id, br_taken, exc_req;
  logic imem_req, hold_pc, hold_if, flush_if, br_sel, exc_sel, imem_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: progress flags, waited cycle count, and a pending
  // redirect target ranked 0=none, 1=branch, 2=exception.
  bit m_started, m_abort;
  int m_wait, m_pend;

  typedef struct {
    logic r, a, s, b, e;
    logic [6:0] exp;
    string name;
  } vec_t;
  vec_t tbl[$];

  if_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
    .stall_id(stall_id), .br_taken(br_taken), .exc_req(exc_req),
    .hold_pc(hold_pc), .hold_if(hold_if), .flush_if(flush_if),
    .br_sel(br_sel), .exc_sel(exc_sel), .imem_err(imem_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, a, s, b, e, logic [6:0] x, string n);
    vec_t v;
    v.r = r; v.a = a; v.s = s; v.b = b; v.e = e; v.exp = x; v.name = n;
    return v;
  endfunction

  task automatic apply(input logic r, a, s, b, e);
    @(negedge clk);
    rst = r; imem_ack = a; stall_id = s; br_taken = b; exc_req = e;
    #2;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {imem_req, hold_pc, hold_if, flush_if, br_sel, exc_sel, imem_err};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, a, s, b, e, output logic [6:0] exp);
    int inc, tgt;
    inc = e ? 2 : (b ? 1 : 0);
    exp = O_IDLE;
    if (r) begin
      m_started = 0; m_abort = 0; m_wait = 0; m_pend = 0;
    end else if (!m_started) begin
      m_pend = (inc > m_pend) ? inc : m_pend;
      m_started = 1;
    end else if (m_abort) begin
      exp = O_ABORT;
      m_pend = 0; m_abort = 0;
    end else if (a) begin
      tgt = (inc > m_pend) ? inc : m_pend;
      if (tgt == 2)      exp = O_EXC;
      else if (tgt == 1) exp = O_BR;
      else if (s)        exp = O_HOLD;
      else               exp = O_ADV;
      m_pend = 0; m_wait = 0;
    end else begin
      exp = s ? O_WSTL : O_WAIT;
      m_pend = (inc > m_pend) ? inc : m_pend;
      if (m_wait == TO - 1) begin
        exp[0] = 1'b1;
        m_pend = 2; m_abort = 1; m_wait = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic step_check(input string name, input logic r, a, s, b, e, input logic [6:0] exp);
    logic [6:0] dummy;
    apply(r, a, s, b, e);
    check(name, exp);
    model_step(r, a, s, b, e, dummy);
  endtask

  initial begin
    logic [6:0] mexp;
    int noack;
    logic r, a, s, b, e;
    rst = 1'b1; imem_ack = 1'b0; stall_id = 1'b0; br_taken = 1'b0; exc_req = 1'b0;

    tbl.push_back(mk(1,1,0,0,0, O_IDLE, "reset_a"));
    tbl.push_back(mk(1,0,0,0,0, O_IDLE, "reset_b"));
    tbl.push_back(mk(0,1,0,0,0, O_IDLE, "first_idle"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "stream_0"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "stream_1"));
    tbl.push_back(mk(0,0,0,0,0, O_WAIT, "delay_w1"));
    tbl.push_back(mk(0,0,0,0,0, O_WAIT, "delay_w2"));
    tbl.push_back(mk(0,0,0,0,0, O_WAIT, "delay_w3"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "delay_ack"));
    tbl.push_back(mk(0,0,0,1,0, O_WAIT, "br_wait1"));
    tbl.push_back(mk(0,0,0,0,0, O_WAIT, "br_wait2"));
    tbl.push_back(mk(0,0,0,0,0, O_WAIT, "br_wait3"));
    tbl.push_back(mk(0,1,0,0,0, O_BR,   "br_ack"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "br_cleared"));
    tbl.push_back(mk(0,1,0,1,1, O_EXC,  "br_exc_same"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "no_late_br"));
    tbl.push_back(mk(0,0,0,0,0, O_WAIT, "no_late_br_w"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "no_late_br_a"));
    tbl.push_back(mk(0,0,0,1,1, O_WAIT, "pend_both"));
    tbl.push_back(mk(0,0,0,1,0, O_WAIT, "br_after_exc"));
    tbl.push_back(mk(0,1,0,0,0, O_EXC,  "pend_exc_ack"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "pend_exc_clr"));
    tbl.push_back(mk(0,1,1,1,0, O_BR,   "redir_ovr_stall"));
    tbl.push_back(mk(0,1,1,0,0, O_HOLD, "stall_1"));
    tbl.push_back(mk(0,1,1,0,0, O_HOLD, "stall_2"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "stall_release"));
    tbl.push_back(mk(0,0,1,0,0, O_WSTL, "wait_stall"));
    tbl.push_back(mk(0,0,0,1,0, O_WAIT, "br_before_rst"));
    tbl.push_back(mk(1,1,0,0,0, O_IDLE, "rst_mid_wait"));
    tbl.push_back(mk(0,1,0,0,0, O_IDLE, "idle_ack_ign"));
    tbl.push_back(mk(0,1,0,0,0, O_ADV,  "pend_rst_clr"));
    tbl.push_back(mk(1,0,0,0,0, O_IDLE, "rst_again"));
    tbl.push_back(mk(0,0,0,1,0, O_IDLE, "idle_br"));
    tbl.push_back(mk(0,0,0,0,0, O_WAIT, "idle_br_w"));
    tbl.push_back(mk(0,1,0,0,0, O_BR,   "idle_br_ack"));

    foreach (tbl[i]) begin
      step_check(tbl[i].name, tbl[i].r, tbl[i].a, tbl[i].s, tbl[i].b, tbl[i].e, tbl[i].exp);
    end

    // Timeout: 14 plain waits, error on the 15th, then ABORT, then FETCH.
    for (int i = 0; i < TO - 1; i++) step_check("to_wait", 0, 0, 0, 0, 0, O_WAIT);
    step_check("to_err", 0, 0, 0, 0, 0, O_TOUT);
    step_check("to_abort", 0, 1, 0, 1, 0, O_ABORT);
    step_check("to_refetch", 0, 1, 0, 0, 0, O_ADV);
    // Counter restarts after an ack: a fresh timeout needs the full count.
    for (int i = 0; i < TO - 1; i++) step_check("to2_wait", 0, 0, 1, 0, 0, O_WSTL);
    step_check("to2_err", 0, 0, 1, 0, 0, O_WSTL | 7'b0000001);
    step_check("to2_abort", 0, 0, 0, 0, 1, O_ABORT);
    step_check("to2_refetch", 0, 1, 0, 0, 0, O_ADV);

    // Randomized run against the reference model.
    noack = 0;
    step_check("rand_reset", 1, 0, 0, 0, 0, O_IDLE);
    for (int c = 0; c < 4000; c++) begin
      if (noack == 0 && $urandom_range(0, 99) < 4) noack = $urandom_range(8, 20);
      if (noack > 0) begin
        a = 1'b0;
        noack--;
      end else begin
        a = 1'($urandom_range(0, 1));
      end
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 6) == 0);
      e = ($urandom_range(0, 9) == 0);
      apply(r, a, s, b, e);
      model_step(r, a, s, b, e, mexp);
      check("random", mexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
